// File: rtl/core_inst_pkg.sv
// Shared definitions for the core instruction sequencer: instruction bit map,
// FSM state codes, field bundle and the idle instruction word.
package core_inst_pkg;

    localparam int AW     = 11;
    localparam int INST_W = 54;

    localparam int B_SRAM_RESET = 53;
    localparam int B_OUT_EN     = 52;
    localparam int B_CEN_PMEM2  = 51;
    localparam int B_WEN_PMEM2  = 50;
    localparam int B_A_PMEM2    = 39;
    localparam int B_CHIP_SEL   = 38;
    localparam int B_RELU       = 34;
    localparam int B_ACC        = 33;
    localparam int B_CEN_PMEM   = 32;
    localparam int B_WEN_PMEM   = 31;
    localparam int B_A_PMEM     = 20;
    localparam int B_CEN_XMEM   = 19;
    localparam int B_WEN_XMEM   = 18;
    localparam int B_A_XMEM     = 7;
    localparam int B_OFIFO_RD   = 4;
    localparam int B_L0_WR      = 3;
    localparam int B_L0_RD      = 2;
    localparam int B_EXECUTE    = 1;
    localparam int B_LOAD       = 0;

    // All SRAM enables/write-enables are active-low, so idle means they are high.
    localparam logic [INST_W-1:0] IDLE_WORD =
        (54'd1 << B_CEN_PMEM2) | (54'd1 << B_WEN_PMEM2) |
        (54'd1 << B_CEN_PMEM)  | (54'd1 << B_WEN_PMEM)  |
        (54'd1 << B_CEN_XMEM)  | (54'd1 << B_WEN_XMEM);

    typedef logic [3:0] state_t;
    localparam state_t ST_IDLE = 4'd0;
    localparam state_t ST_CLR  = 4'd1;
    localparam state_t ST_WLD  = 4'd2;
    localparam state_t ST_KLD  = 4'd3;
    localparam state_t ST_ACT  = 4'd4;
    localparam state_t ST_DRN  = 4'd5;
    localparam state_t ST_ACC  = 4'd6;
    localparam state_t ST_OUT  = 4'd7;
    localparam state_t ST_DONE = 4'd8;

    typedef struct packed {
        logic          sram_reset;
        logic          out_en;
        logic          cen_pmem2;
        logic          wen_pmem2;
        logic [AW-1:0] a_pmem2;
        logic          chip_sel;
        logic          relu;
        logic          acc;
        logic          cen_pmem;
        logic          wen_pmem;
        logic [AW-1:0] a_pmem;
        logic          cen_xmem;
        logic          wen_xmem;
        logic [AW-1:0] a_xmem;
        logic          ofifo_rd;
        logic          l0_wr;
        logic          l0_rd;
        logic          execute;
        logic          load;
    } inst_fields_t;

    function automatic inst_fields_t idle_fields();
        inst_fields_t f;
        f           = {$bits(inst_fields_t){1'b0}};
        f.cen_pmem2 = 1'b1;
        f.wen_pmem2 = 1'b1;
        f.cen_pmem  = 1'b1;
        f.wen_pmem  = 1'b1;
        f.cen_xmem  = 1'b1;
        f.wen_xmem  = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/core_inst_pack.sv
// Combinational packer from named instruction fields to the 54-bit core word;
// reused by the core-level checker so both agree on the bit map.
module core_inst_pack
    import core_inst_pkg::*;
(
    input  inst_fields_t      fields,
    output logic [INST_W-1:0] word
);

    // Place every field at its bit position; sfp[37:35] and corelet[6:5] stay zero
    always_comb begin
        word                    = {INST_W{1'b0}};
        word[B_SRAM_RESET]      = fields.sram_reset;
        word[B_OUT_EN]          = fields.out_en;
        word[B_CEN_PMEM2]       = fields.cen_pmem2;
        word[B_WEN_PMEM2]       = fields.wen_pmem2;
        word[B_A_PMEM2 +: AW]   = fields.a_pmem2;
        word[B_CHIP_SEL]        = fields.chip_sel;
        word[B_RELU]            = fields.relu;
        word[B_ACC]             = fields.acc;
        word[B_CEN_PMEM]        = fields.cen_pmem;
        word[B_WEN_PMEM]        = fields.wen_pmem;
        word[B_A_PMEM +: AW]    = fields.a_pmem;
        word[B_CEN_XMEM]        = fields.cen_xmem;
        word[B_WEN_XMEM]        = fields.wen_xmem;
        word[B_A_XMEM +: AW]    = fields.a_xmem;
        word[B_OFIFO_RD]        = fields.ofifo_rd;
        word[B_L0_WR]           = fields.l0_wr;
        word[B_L0_RD]           = fields.l0_rd;
        word[B_EXECUTE]         = fields.execute;
        word[B_LOAD]            = fields.load;
    end

endmodule

// File: rtl/core_inst_seq.sv
// Job sequencer for the systolic core: clears psum banks, runs every tile
// (weight load, kernel load, activations, drain, ping-pong accumulate), then reads out.
module core_inst_seq
    import core_inst_pkg::*;
#(
    parameter int ROW   = 8,
    parameter int COL   = 8,
    parameter int DRAIN = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        n_tiles,
    input  logic [AW-1:0]     len,
    input  logic [AW-1:0]     w_base,
    input  logic [AW-1:0]     a_base,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    // Phase counter must reach len (up to 2^AW-1) inclusive.
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] ROW_LAST   = CW'(ROW);
    localparam logic [CW-1:0] COL_LAST   = CW'(COL - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN - 1);

    state_t            state_r, state_s;
    logic [CW-1:0]     cnt_r, cnt_s;
    logic [3:0]        t_r, t_s;
    logic [3:0]        nt_r, nt_s;
    logic [AW-1:0]     len_r, len_s;
    logic [AW-1:0]     wb_r, wb_s;
    logic [AW-1:0]     ab_r, ab_s;
    logic [INST_W-1:0] inst_r;
    logic              busy_r, done_r;

    inst_fields_t      f_s;
    logic [INST_W-1:0] word_s;
    logic              in_row_s, in_len_s, nz_s, more_tiles_s;
    logic [AW-1:0]     rd_a_s, wr_a_s;

    assign more_tiles_s = ({1'b0, t_r} + 5'd1) < {1'b0, nt_r};

    // Next state, counters and sampled job configuration
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r + CW'(1);
        t_s     = t_r;
        nt_s    = nt_r;
        len_s   = len_r;
        wb_s    = wb_r;
        ab_s    = ab_r;
        case (state_r)
            ST_IDLE: begin
                cnt_s = {CW{1'b0}};
                if (start) begin
                    nt_s  = n_tiles;
                    len_s = len;
                    wb_s  = w_base;
                    ab_s  = a_base;
                    t_s   = 4'd0;
                    if ((n_tiles != 4'd0) && (len != {AW{1'b0}})) begin
                        state_s = ST_CLR;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLR: begin
                state_s = ST_WLD;
                cnt_s   = {CW{1'b0}};
            end
            ST_WLD: begin
                if (cnt_r == ROW_LAST) begin
                    state_s = ST_KLD;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    state_s = ST_WLD;
                end
            end
            ST_KLD: begin
                if (cnt_r == COL_LAST) begin
                    state_s = ST_ACT;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    state_s = ST_KLD;
                end
            end
            ST_ACT: begin
                if (cnt_r == {1'b0, len_r}) begin
                    state_s = ST_DRN;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    state_s = ST_ACT;
                end
            end
            ST_DRN: begin
                if (cnt_r == DRAIN_LAST) begin
                    state_s = ST_ACC;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    state_s = ST_DRN;
                end
            end
            ST_ACC: begin
                if (cnt_r == {1'b0, len_r}) begin
                    cnt_s = {CW{1'b0}};
                    if (more_tiles_s) begin
                        state_s = ST_WLD;
                        t_s     = t_r + 4'd1;
                        wb_s    = wb_r + AW'(ROW);
                        ab_s    = ab_r + len_r;
                    end else begin
                        state_s = ST_OUT;
                    end
                end else begin
                    state_s = ST_ACC;
                end
            end
            ST_OUT: begin
                if (cnt_r == {1'b0, len_r}) begin
                    state_s = ST_DONE;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    state_s = ST_OUT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                cnt_s   = {CW{1'b0}};
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    assign in_row_s = cnt_s < ROW_LAST;
    assign in_len_s = cnt_s < {1'b0, len_s};
    assign nz_s     = cnt_s != {CW{1'b0}};
    assign rd_a_s   = in_len_s ? cnt_s[AW-1:0] : {AW{1'b0}};
    assign wr_a_s   = nz_s ? (cnt_s[AW-1:0] - AW'(1)) : {AW{1'b0}};

    // Instruction fields for the cycle being entered (inst has no extra lag)
    always_comb begin
        f_s = idle_fields();
        case (state_s)
            ST_CLR: f_s.sram_reset = 1'b1;
            ST_WLD: begin
                f_s.cen_xmem = ~in_row_s;
                f_s.a_xmem   = in_row_s ? (wb_s + cnt_s[AW-1:0]) : {AW{1'b0}};
                f_s.l0_wr    = nz_s;
            end
            ST_KLD: begin
                f_s.load  = 1'b1;
                f_s.l0_rd = 1'b1;
            end
            ST_ACT: begin
                f_s.cen_xmem = ~in_len_s;
                f_s.a_xmem   = in_len_s ? (ab_s + cnt_s[AW-1:0]) : {AW{1'b0}};
                f_s.l0_wr    = nz_s;
                f_s.execute  = nz_s;
            end
            ST_ACC: begin
                f_s.chip_sel = t_s[0];
                f_s.relu     = ({1'b0, t_s} + 5'd1) == {1'b0, nt_s};
                f_s.ofifo_rd = in_len_s;
                f_s.acc      = in_len_s;
                // Odd tiles read pmem2 and write pmem1; even tiles the reverse
                if (t_s[0]) begin
                    f_s.cen_pmem2 = ~in_len_s;
                    f_s.a_pmem2   = rd_a_s;
                    f_s.cen_pmem  = ~nz_s;
                    f_s.wen_pmem  = ~nz_s;
                    f_s.a_pmem    = wr_a_s;
                end else begin
                    f_s.cen_pmem  = ~in_len_s;
                    f_s.a_pmem    = rd_a_s;
                    f_s.cen_pmem2 = ~nz_s;
                    f_s.wen_pmem2 = ~nz_s;
                    f_s.a_pmem2   = wr_a_s;
                end
            end
            ST_OUT: begin
                f_s.chip_sel = nt_s[0];
                f_s.out_en   = nz_s;
                if (nt_s[0]) begin
                    f_s.cen_pmem2 = ~in_len_s;
                    f_s.a_pmem2   = rd_a_s;
                end else begin
                    f_s.cen_pmem = ~in_len_s;
                    f_s.a_pmem   = rd_a_s;
                end
            end
            default: f_s = idle_fields();
        endcase
    end

    core_inst_pack u_pack (
        .fields (f_s),
        .word   (word_s)
    );

    // State, counters, job configuration and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            t_r     <= 4'd0;
            nt_r    <= 4'd0;
            len_r   <= {AW{1'b0}};
            wb_r    <= {AW{1'b0}};
            ab_r    <= {AW{1'b0}};
            inst_r  <= IDLE_WORD;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            t_r     <= t_s;
            nt_r    <= nt_s;
            len_r   <= len_s;
            wb_r    <= wb_s;
            ab_r    <= ab_s;
            inst_r  <= word_s;
            busy_r  <= (state_s != ST_IDLE) && (state_s != ST_DONE);
            done_r  <= state_s == ST_DONE;
        end
    end

    assign inst = inst_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_core_inst_seq.sv
// Self-checking bench for core_inst_seq: a per-job reference trace is built from
// the phase rules with plain loops and compared against inst/busy/done every cycle.
`timescale 1ns/1ps
module tb_core_inst_seq;

    localparam int ROW   = 8;
    localparam int COL   = 8;
    localparam int DRAIN = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  n_tiles;
    logic [10:0] len;
    logic [10:0] w_base;
    logic [10:0] a_base;
    logic [53:0] inst;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [53:0] w;
        logic        b;
        logic        d;
    } cyc_t;

    cyc_t        exp_q[$];
    logic [53:0] idle_w;

    always #5 clk = ~clk;

    core_inst_seq #(.ROW(ROW), .COL(COL), .DRAIN(DRAIN)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .n_tiles (n_tiles),
        .len     (len),
        .w_base  (w_base),
        .a_base  (a_base),
        .inst    (inst),
        .busy    (busy),
        .done    (done)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [53:0] xmem_rd(input logic [53:0] w, input int a);
        w[19]   = 1'b0;
        w[17:7] = 11'(a);
        return w;
    endfunction

    // bank 1 = pmem (CEN 32, WEN 31, A 30:20); bank 2 = pmem2 (CEN 51, WEN 50, A 49:39)
    function automatic logic [53:0] pmem_acc(input logic [53:0] w, input int bank, input bit wr, input int a);
        if (bank == 1) begin
            w[32]    = 1'b0;
            w[31]    = ~wr;
            w[30:20] = 11'(a);
        end else begin
            w[51]    = 1'b0;
            w[50]    = ~wr;
            w[49:39] = 11'(a);
        end
        return w;
    endfunction

    task automatic push(input logic [53:0] w, input logic b, input logic d);
        cyc_t c;
        c.w = w;
        c.b = b;
        c.d = d;
        exp_q.push_back(c);
    endtask

    // Expected trace from the cycle after the accepted start through the DONE cycle
    task automatic build_job(input int nt, input int ln, input int wb, input int ab);
        logic [53:0] w;
        exp_q.delete();
        if (nt == 0 || ln == 0) begin
            push(idle_w, 1'b0, 1'b1);
            return;
        end
        w = idle_w; w[53] = 1'b1; push(w, 1'b1, 1'b0);
        for (int t = 0; t < nt; t++) begin
            int rd_bank = (t % 2 == 0) ? 1 : 2;
            int wr_bank = 3 - rd_bank;
            for (int i = 0; i <= ROW; i++) begin
                w = idle_w;
                if (i < ROW) w = xmem_rd(w, wb + t * ROW + i);
                if (i >= 1) w[3] = 1'b1;
                push(w, 1'b1, 1'b0);
            end
            for (int i = 0; i < COL; i++) begin
                w = idle_w; w[0] = 1'b1; w[2] = 1'b1;
                push(w, 1'b1, 1'b0);
            end
            for (int i = 0; i <= ln; i++) begin
                w = idle_w;
                if (i < ln) w = xmem_rd(w, ab + t * ln + i);
                if (i >= 1) begin w[3] = 1'b1; w[1] = 1'b1; end
                push(w, 1'b1, 1'b0);
            end
            for (int i = 0; i < DRAIN; i++) push(idle_w, 1'b1, 1'b0);
            for (int j = 0; j <= ln; j++) begin
                w = idle_w;
                w[38] = (t % 2 == 1);
                w[34] = (t == nt - 1);
                if (j < ln) begin
                    w[4] = 1'b1; w[33] = 1'b1;
                    w = pmem_acc(w, rd_bank, 1'b0, j);
                end
                if (j >= 1) w = pmem_acc(w, wr_bank, 1'b1, j - 1);
                push(w, 1'b1, 1'b0);
            end
        end
        for (int j = 0; j <= ln; j++) begin
            w = idle_w;
            w[38] = (nt % 2 == 1);
            if (j < ln) w = pmem_acc(w, (nt % 2 == 1) ? 2 : 1, 1'b0, j);
            if (j >= 1) w[52] = 1'b1;
            push(w, 1'b1, 1'b0);
        end
        push(idle_w, 1'b0, 1'b1);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_inst"}, inst, idle_w);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_done"}, done, 1'b0);
    endtask

    // Runs one job; stray = trace index where an ignored start is pulsed,
    // abort_at = trace index after which reset is applied (-1 for none)
    task automatic run_job(input int nt, input int ln, input int wb, input int ab,
                           input int stray, input int abort_at);
        int dones = 0;
        build_job(nt, ln, wb, ab);
        n_tiles = 4'(nt); len = 11'(ln); w_base = 11'(wb); a_base = 11'(ab);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tiles = 4'($urandom); len = 11'($urandom); w_base = 11'($urandom); a_base = 11'($urandom);
        for (int k = 0; k < exp_q.size(); k++) begin
            check_eq("inst", inst, exp_q[k].w);
            check_eq("busy", busy, exp_q[k].b);
            check_eq("done", done, exp_q[k].d);
            if (done) dones++;
            if (k == abort_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check_idle("abort");
                for (int i = 0; i < 4; i++) begin
                    tick();
                    check_idle("abort_quiet");
                end
                return;
            end
            if (k == stray) start = 1'b1;
            if (k == exp_q.size() - 1) begin
                n_tiles = 4'd1; len = 11'd1; start = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        check_idle("post_done");
        check_eq("done_count", 64'(dones), 64'd1);
    endtask

    initial begin
        idle_w = 54'd0;
        idle_w[51] = 1'b1; idle_w[50] = 1'b1; idle_w[32] = 1'b1;
        idle_w[31] = 1'b1; idle_w[19] = 1'b1; idle_w[18] = 1'b1;

        reset = 1'b1; start = 1'b0;
        n_tiles = 4'd0; len = 11'd0; w_base = 11'd0; a_base = 11'd0;
        repeat (3) tick();
        check_idle("reset");
        reset = 1'b0;
        tick();
        check_idle("after_reset");

        // single tile, xmem 0..7 then 16..19, pmem2 written, OUT reads pmem2
        run_job(1, 4, 0, 16, 30, -1);
        // three tiles: chip_sel 0,1,0; relu only in last ACC; OUT chip_sel=1
        run_job(3, 2, int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)), 50, -1);
        // zero fields go straight to DONE
        run_job(1, 0, 5, 5, -1, -1);
        run_job(0, 3, 5, 5, -1, -1);
        // address wrap on weights and activations
        run_job(2, 3, 2040, 2045, 12, -1);
        // reset during ACT of tile 1, then a clean job
        run_job(2, 3, 10, 200, -1, 1 + (ROW + 1 + COL + 4 + DRAIN + 4) + (ROW + 1) + COL + 1);
        run_job(2, 3, 10, 200, 7, -1);
        // randomized jobs
        for (int r = 0; r < 12; r++) begin
            int nt = int'($urandom_range(0, 4));
            int ln = int'($urandom_range(0, 6));
            run_job(nt, ln, int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                    int'($urandom_range(0, 60)), -1);
            repeat (int'($urandom_range(0, 3))) begin
                tick();
                check_idle("gap");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
